// File: rtl/dnn_pkg.sv
// Shared types and defaults for the MNIST inference controller.
package dnn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_BIAS,
      ST_START,
      ST_RUN,
      ST_ARGMAX,
      ST_RESULT,
      ST_CLEAR
   } state_t;

   typedef logic signed [13:0] q212_t;

   localparam q212_t       ONE_Q212        = 14'h1000;
   localparam logic [15:0] ADDR_BASE_A_DEF = 16'h0000;
   localparam int          N_PIX_DEF       = 400;
   localparam int          N_OUT_DEF       = 10;

endpackage

// File: rtl/dnn_argmax_seq.sv
// Sequential signed argmax over N packed words, one candidate per cycle.
// Ties keep the lower index because only a strictly greater word replaces the best.
module dnn_argmax_seq #(
   parameter int W = 14,
   parameter int N = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N*W-1:0] vec,
   output logic           busy,
   output logic           done,
   output logic [3:0]     cls,
   output logic [W-1:0]   score
);

   logic [3:0]   idx;
   logic [W-1:0] cand;

   assign cand = vec[int'(idx)*W +: W];
   assign done = busy && (idx == 4'(N-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy  <= 1'b0;
         idx   <= '0;
         cls   <= '0;
         score <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         idx   <= 4'd1;
         cls   <= '0;
         score <= vec[W-1:0];
      end else if (busy) begin
         if ($signed(cand) > $signed(score)) begin
            score <= cand;
            cls   <= idx;
         end
         if (done) begin
            busy <= 1'b0;
         end
         idx <= idx + 4'd1;
      end
   end

endmodule

// File: rtl/dnn_infer_ctrl.sv
// Inference sequencer: loads an image and bias into activation memory, runs the engine,
// reduces its outputs by argmax. Optional DNN_CTRL_PERF_EN adds an engine cycle counter.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | ready for the first pixel of a new image
// ST_LOAD   | writing accepted pixels
// ST_BIAS   | writing the bias word after the last pixel
// ST_START  | eng_start pulse, engine owns the address port
// ST_RUN    | waiting for eng_done
// ST_ARGMAX | sequential reduction of engine outputs
// ST_RESULT | res_valid held until consumed
// ST_CLEAR  | eng_reset pulse, then back to idle
module dnn_infer_ctrl
   import dnn_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 14,
   parameter int                    ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = ADDR_BASE_A_DEF,
   parameter int                    N_PIX       = N_PIX_DEF,
   parameter int                    N_OUT       = N_OUT_DEF,
   parameter logic [DATA_WIDTH-1:0] BIAS_VAL    = ONE_Q212
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pix_valid,
   output logic                        pix_ready,
   input  logic [DATA_WIDTH-1:0]       pix_data,
   output logic                        mem_we,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]       mem_wdata,
   input  logic [ADDR_WIDTH-1:0]       eng_mem_addr,
   output logic                        eng_start,
   output logic                        eng_reset,
   input  logic                        eng_done,
   input  logic [N_OUT*DATA_WIDTH-1:0] eng_out,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [3:0]                  res_class,
   output logic [DATA_WIDTH-1:0]       res_score,
`ifdef DNN_CTRL_PERF_EN
   output logic [31:0]                 perf_cycles,
`endif
   output logic                        busy
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(N_PIX-1);
   localparam logic [ADDR_WIDTH-1:0] BIAS_ADDR = ADDR_BASE_A + ADDR_WIDTH'(N_PIX);

   state_t                state;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  accept;
   logic                  am_start;
   logic                  am_busy;
   logic                  am_done;

   // Gated by rst so the port reads zero during reset yet accepts from the first clock after.
   assign pix_ready = rst && ((state == ST_IDLE) || (state == ST_LOAD));
   assign accept    = pix_valid && pix_ready;
   assign am_start  = (state == ST_RUN) && eng_done;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = ADDR_BASE_A;
      mem_wdata = '0;
      if (!rst) begin
         mem_addr = '0;
      end else if (accept) begin
         mem_we    = 1'b1;
         mem_addr  = ADDR_BASE_A + idx;
         mem_wdata = pix_data;
      end else if (state == ST_BIAS) begin
         mem_we    = 1'b1;
         mem_addr  = BIAS_ADDR;
         mem_wdata = BIAS_VAL;
      end else if ((state == ST_START) || (state == ST_RUN) || (state == ST_ARGMAX)) begin
         mem_addr = eng_mem_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         eng_start <= 1'b0;
         eng_reset <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_LOAD: begin
               if (accept) begin
                  busy <= 1'b1;
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     state <= ST_BIAS;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= ST_LOAD;
                  end
               end
            end
            ST_BIAS: begin
               eng_start <= 1'b1;
               state     <= ST_START;
            end
            ST_START: begin
               eng_start <= 1'b0;
               state     <= ST_RUN;
            end
            ST_RUN: begin
               if (eng_done) begin
                  state <= ST_ARGMAX;
               end
            end
            ST_ARGMAX: begin
               if (am_busy && am_done) begin
                  res_valid <= 1'b1;
                  state     <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  eng_reset <= 1'b1;
                  state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               eng_reset <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   dnn_argmax_seq #(
      .W (DATA_WIDTH),
      .N (N_OUT)
   ) u_argmax (
      .clk   (clk),
      .rst   (rst),
      .start (am_start),
      .vec   (eng_out),
      .busy  (am_busy),
      .done  (am_done),
      .cls   (res_class),
      .score (res_score)
   );

`ifdef DNN_CTRL_PERF_EN
   // Counts START plus every RUN cycle, so the eng_done cycle is included.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles <= '0;
      end else if (state == ST_START) begin
         perf_cycles <= 32'd1;
      end else if ((state == ST_RUN) && (perf_cycles != 32'hFFFF_FFFF)) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Self-checking bench for dnn_infer_ctrl; checks perf_cycles when DNN_CTRL_PERF_EN is defined.
module tb_dnn_infer_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_valid;
   logic          pix_ready;
   logic [13:0]   pix_data;
   logic          mem_we;
   logic [15:0]   mem_addr;
   logic [13:0]   mem_wdata;
   logic [15:0]   eng_mem_addr;
   logic          eng_start;
   logic          eng_reset;
   logic          eng_done;
   logic [139:0]  eng_out;
   logic          res_valid;
   logic          res_ready;
   logic [3:0]    res_class;
   logic [13:0]   res_score;
   logic          busy;
`ifdef DNN_CTRL_PERF_EN
   logic [31:0]   perf_cycles;
`endif

   logic [13:0]   img [400];
   logic [13:0]   eo  [10];
   int            n_chk  = 0;
   int            n_fail = 0;
   int            cyc    = 0;
   int            first_cyc;
   int            start_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      eng_out = '0;
      for (int i = 0; i < 10; i++) eng_out[i*14 +: 14] = eo[i];
   end

   dnn_infer_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_data     (pix_data),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .eng_mem_addr (eng_mem_addr),
      .eng_start    (eng_start),
      .eng_reset    (eng_reset),
      .eng_done     (eng_done),
      .eng_out      (eng_out),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_class    (res_class),
      .res_score    (res_score),
`ifdef DNN_CTRL_PERF_EN
      .perf_cycles  (perf_cycles),
`endif
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference argmax: first index holding the largest signed value.
   function automatic int exp_class();
      int b = 0;
      for (int i = 1; i < 10; i++)
         if ($signed(eo[i]) > $signed(eo[b])) b = i;
      return b;
   endfunction

   task automatic chk_reset_zero();
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_eng_start", 32'(eng_start), 32'd0);
      chk("rst_eng_reset", 32'(eng_reset), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_class", 32'(res_class), 32'd0);
      chk("rst_res_score", 32'(res_score), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
`ifdef DNN_CTRL_PERF_EN
      chk("rst_perf",      perf_cycles,    32'd0);
`endif
   endtask

   task automatic load_pixels(input int n, input int gap_pct, output int first);
      int k = 0;
      int guard = 0;
      first = -1;
      while (k < n && guard < 4000) begin
         @(negedge clk);
         guard++;
         pix_valid    = ($urandom_range(99) >= gap_pct);
         pix_data     = img[k];
         eng_mem_addr = 16'($urandom);
         #1;
         chk("load_pix_ready", 32'(pix_ready), 32'd1);
         chk("load_mem_we", 32'(mem_we), 32'(pix_valid));
         if (pix_valid) begin
            if (first < 0) first = cyc;
            chk("load_addr", 32'(mem_addr), 32'(k));
            chk("load_data", 32'(mem_wdata), 32'(img[k]));
            k++;
         end else begin
            chk("load_gap_addr", 32'(mem_addr), 32'd0);
         end
      end
      chk("load_count", 32'(k), 32'(n));
   endtask

   task automatic run_engine(input int lat, input int rdy_delay, output int scyc);
      int          w;
      logic [3:0]  ec;
      logic [13:0] es;
      ec = 4'(exp_class());
      es = eo[exp_class()];
      res_ready = (rdy_delay == 0);

      @(negedge clk);
      pix_valid    = 1'($urandom);
      eng_mem_addr = 16'($urandom);
      #1;
      chk("bias_we",        32'(mem_we),    32'd1);
      chk("bias_addr",      32'(mem_addr),  32'd400);
      chk("bias_data",      32'(mem_wdata), 32'h1000);
      chk("bias_pix_ready", 32'(pix_ready), 32'd0);
      chk("bias_eng_start", 32'(eng_start), 32'd0);

      @(negedge clk);
      eng_mem_addr = 16'($urandom);
      #1;
      scyc = cyc;
      chk("start_pulse", 32'(eng_start), 32'd1);
      chk("start_addr",  32'(mem_addr),  32'(eng_mem_addr));
      chk("start_we",    32'(mem_we),    32'd0);

      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         pix_valid    = 1'($urandom);
         eng_mem_addr = 16'($urandom);
         eng_done     = (c == lat);
         #1;
         chk("run_eng_start", 32'(eng_start), 32'd0);
         chk("run_addr",      32'(mem_addr),  32'(eng_mem_addr));
         chk("run_pix_ready", 32'(pix_ready), 32'd0);
         chk("run_we",        32'(mem_we),    32'd0);
         chk("run_res_valid", 32'(res_valid), 32'd0);
         chk("run_busy",      32'(busy),      32'd1);
      end

      w = 0;
      do begin
         @(negedge clk);
         eng_mem_addr = 16'($urandom);
         #1;
         w++;
         if (!res_valid) chk("argmax_addr", 32'(mem_addr), 32'(eng_mem_addr));
      end while (!res_valid && w < 30);
      chk("argmax_latency", 32'(w), 32'd10);
      chk("res_class",      32'(res_class), 32'(ec));
      chk("res_score",      32'(res_score), 32'(es));
      chk("result_addr",    32'(mem_addr),  32'd0);
      chk("result_eng_rst", 32'(eng_reset), 32'd0);

      for (int i = 1; i <= rdy_delay; i++) begin
         @(negedge clk);
         res_ready = (i == rdy_delay);
         #1;
         chk("hold_valid",   32'(res_valid), 32'd1);
         chk("hold_class",   32'(res_class), 32'(ec));
         chk("hold_score",   32'(res_score), 32'(es));
         chk("hold_eng_rst", 32'(eng_reset), 32'd0);
      end

      @(negedge clk);
      res_ready = 1'b0;
      #1;
      chk("clear_eng_reset", 32'(eng_reset), 32'd1);
      chk("clear_res_valid", 32'(res_valid), 32'd0);
      chk("clear_busy",      32'(busy),      32'd1);
      chk("clear_pix_ready", 32'(pix_ready), 32'd0);
      chk("clear_class",     32'(res_class), 32'(ec));

      @(negedge clk);
      eng_done  = 1'b0;
      pix_valid = 1'b0;
      #1;
      chk("idle_eng_reset", 32'(eng_reset), 32'd0);
      chk("idle_busy",      32'(busy),      32'd0);
      chk("idle_pix_ready", 32'(pix_ready), 32'd1);
      chk("idle_class",     32'(res_class), 32'(ec));
      chk("idle_score",     32'(res_score), 32'(es));
`ifdef DNN_CTRL_PERF_EN
      chk("perf_cycles",    perf_cycles,    32'(lat + 1));
`endif
   endtask

   initial begin
      rst          = 1'b0;
      pix_valid    = 1'b1;
      pix_data     = 14'h0123;
      eng_mem_addr = 16'h5A5A;
      eng_done     = 1'b0;
      res_ready    = 1'b0;
      for (int i = 0; i < 10; i++) eo[i] = '0;

      repeat (2) @(negedge clk);
      #1;
      chk_reset_zero();
      @(negedge clk);
      rst       = 1'b1;
      pix_valid = 1'b0;
      #1;
      chk("post_rst_pix_ready", 32'(pix_ready), 32'd1);

      // Constant image, no gaps, index 7 wins, consumer already ready.
      for (int k = 0; k < 400; k++) img[k] = 14'h0100;
      for (int i = 0; i < 10; i++) eo[i] = 14'h0000;
      eo[7] = 14'h0800;
      load_pixels(400, 0, first_cyc);
      run_engine(5, 0, start_cyc);
      chk("start_latency", 32'(start_cyc - first_cyc), 32'd401);

      // eng_done outside RUN must not start anything.
      @(negedge clk);
      eng_done = 1'b1;
      #1;
      @(negedge clk);
      eng_done = 1'b0;
      #1;
      chk("stray_done_busy",  32'(busy),      32'd0);
      chk("stray_done_start", 32'(eng_start), 32'd0);

      // All negative outputs, slow consumer.
      for (int k = 0; k < 400; k++) img[k] = 14'($urandom);
      for (int i = 0; i < 10; i++) eo[i] = 14'h3F00;
      eo[3] = 14'h3F80;
      load_pixels(400, 30, first_cyc);
      run_engine(37, 20, start_cyc);

      // Tie on the maximum, plus a large negative at index 0.
      for (int k = 0; k < 400; k++) img[k] = 14'($urandom);
      for (int i = 0; i < 10; i++) eo[i] = 14'($urandom_range(0, 14'h03FF));
      eo[0] = 14'h3000;
      eo[2] = 14'h0400;
      eo[5] = 14'h0400;
      load_pixels(400, 15, first_cyc);
      run_engine(12, 3, start_cyc);

      // Reset mid-load, then a fresh image.
      load_pixels(150, 10, first_cyc);
      @(negedge clk);
      rst       = 1'b0;
      pix_valid = 1'b1;
      #1;
      chk_reset_zero();
      @(negedge clk);
      rst       = 1'b1;
      pix_valid = 1'b0;
      #1;
      chk("rerst_pix_ready", 32'(pix_ready), 32'd1);
      chk("rerst_busy",      32'(busy),      32'd0);
      for (int k = 0; k < 400; k++) img[k] = 14'($urandom);
      for (int i = 0; i < 10; i++) eo[i] = 14'($urandom);
      load_pixels(400, 20, first_cyc);
      run_engine(int'($urandom_range(1, 50)), int'($urandom_range(0, 5)), start_cyc);

      // Further randomized rounds.
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 400; k++) img[k] = 14'($urandom);
         for (int i = 0; i < 10; i++) eo[i] = 14'($urandom);
         load_pixels(400, int'($urandom_range(0, 40)), first_cyc);
         run_engine(int'($urandom_range(1, 60)), int'($urandom_range(0, 8)), start_cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dnn_infer_ctrl.md
# dnn_infer_ctrl

Top-level inference sequencer for the fixed-point MNIST engine. Accepts a 20x20 image as a pixel stream and writes it, plus the constant bias word, into the activation region of the shared parameter memory. It then starts the engine and lends it the memory address port, reduces the 10 engine outputs to a winning class by sequential argmax, and returns the engine to idle after the result is consumed.

## Interface
- DATA_WIDTH, 14: fixed-point word width (Q2.12).
- ADDR_WIDTH, 16: memory address width.
- ADDR_BASE_A, 16'h0000: base of the activation region.
- N_PIX, 400: pixels per image; the bias word is written at ADDR_BASE_A+N_PIX.
- N_OUT, 10: engine output count.
- BIAS_VAL, 14'b01000000000000: bias activation word (1.0).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel stream valid.
- pix_ready  out  1  controller accepts a pixel.
- pix_data  in  DATA_WIDTH  signed pixel value.
- mem_we  out  1  write strobe to activation memory.
- mem_addr  out  ADDR_WIDTH  shared memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- eng_mem_addr  in  ADDR_WIDTH  engine address request.
- eng_start  out  1  one-cycle engine start pulse.
- eng_reset  out  1  one-cycle engine clear pulse.
- eng_done  in  1  engine done; held until eng_reset.
- eng_out  in  DATA_WIDTH x N_OUT  signed engine outputs, stable while eng_done=1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_class  out  4  winning index 0..9.
- res_score  out  DATA_WIDTH  winning output value.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine, with state changes on the rising edge of clk:
  - IDLE: pix_ready=1. The first accepted pixel goes to LOAD.
  - LOAD: write each accepted pixel.
  - BIAS: write the bias word.
  - START: pulse eng_start.
  - RUN: wait for eng_done.
  - ARGMAX: run the reduction.
  - RESULT: hold res_valid.
  - CLEAR: pulse eng_reset, then go to IDLE.
- Pixel acceptance: pix_valid & pix_ready. Each accepted pixel is written combinationally in the same cycle:
  - mem_we=1
  - mem_addr=ADDR_BASE_A+idx
  - mem_wdata=pix_data
- idx counts 0..N_PIX-1. When pixel N_PIX-1 is accepted, go to BIAS. pix_ready=1 only in IDLE and LOAD.
- BIAS (one cycle): mem_we=1, mem_addr=ADDR_BASE_A+N_PIX, mem_wdata=BIAS_VAL.
- Memory port mux: mem_addr=eng_mem_addr in START, RUN and ARGMAX. In all other non-write cycles it is ADDR_BASE_A. mem_we=0 except in LOAD writes and BIAS.
- Argmax:
  - Initialise best=eng_out[0], class=0.
  - Compare indices 1..N_OUT-1, one per cycle, using a signed comparison.
  - Replace best only when strictly greater, so ties resolve to the lowest index.
  - Takes N_OUT-1 cycles, then go to RESULT.
- RESULT: res_valid=1 with res_class/res_score stable until res_valid & res_ready, then go to CLEAR. res_class/res_score keep their value after the handshake until the next argmax starts.
- A pixel offered outside IDLE/LOAD is not accepted (pix_ready=0). It is never dropped silently.
- eng_done seen in any state other than RUN is ignored.
- Reset (rst=0) at any time, including mid-load or mid-run:
  - State returns to IDLE and idx=0.
  - These outputs are 0: pix_ready, mem_we, mem_addr, mem_wdata, eng_start, eng_reset, res_valid, res_class, res_score, busy.
  - After rst deasserts, pix_ready=1 from the first clock.
  - An interrupted engine is cleared by the next CLEAR. The integrator also ties the engine's own reset to the same rst.

## Timing
- Image to engine start: N_PIX+2 cycles minimum (N_PIX load cycles, BIAS, START). Gaps in pix_valid stretch LOAD cycle-for-cycle.
- eng_start is high exactly one cycle. RUN is entered in the next cycle.
- eng_done sampled high in RUN: ARGMAX starts in the next cycle; res_valid rises N_OUT-1 cycles later (9 for defaults).
- res_ready already high: handshake completes in the first RESULT cycle. eng_reset is high the following cycle, with IDLE one cycle after that.

## Configuration
- DNN_CTRL_PERF_EN defined:
  - Adds output perf_cycles[31:0].
  - Counts cycles from eng_start through the cycle eng_done is first sampled, inclusive.
  - Holds the count until the next eng_start.
  - Reset value is 0 and it saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package dnn_pkg holds:
  - the state enum;
  - the Q2.12 word typedef;
  - ONE_Q212 = 14'h1000;
  - default address bases, N_PIX and N_OUT.
- Sub-module dnn_argmax_seq contains the sequential signed argmax: start/busy/done handshake, input vector, class/score outputs.

## Test plan
- Full image of 400 pixels, value 14'h0100, pix_valid always high:
  - writes to addresses 0..399, then address 400 = 14'h1000;
  - eng_start at cycle 402.
- eng_out = {0,0,0,0,0,0,0,14'h0800,0,0} (index 7 = 14'h0800) → res_class=7, res_score=14'h0800, 9 cycles after eng_done.
- eng_out all 14'h3F00 (negative), with index 3 = 14'h3F80 → res_class=3; signed compare verified.
- Tie with indices 2 and 5 both = 14'h0400 (the maximum) → res_class=2.
- res_ready held low for 20 cycles → res_valid and outputs stable the whole time; eng_reset is pulsed exactly once after the handshake.
- rst pulsed low after 150 pixels → all outputs 0; a fresh 400-pixel image then completes normally. With DNN_CTRL_PERF_EN and eng_done 37 cycles after eng_start, perf_cycles=38.
